apb_reg_read_ctrl: RTL
======================

# apb_reg_read_ctrl

Parametrised APB slave read-back controller for the interrupt controller register bank. It decodes a register index from PADDR against a configurable base address and register count, and returns registered read data with a programmable number of wait states. Unmapped or misaligned accesses are flagged on PSLVERR. A per-read strobe supports read-sensitive registers such as read-to-clear status. It sits between the APB interface and the register file, replacing the fixed combinational read mux.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, register and PRDATA width
- NUM_REGS, 20, number of mapped registers (1..64); register i is at ADDR_BASE + 4*i
- ADDR_BASE, 32'h0009_0000, byte address of register 0; must be 4-byte aligned
- WAIT_STATES, 0, access-phase wait cycles before PREADY (0..15)

Ports:
- PCLK  in  1  clock; all state changes on the rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable (access phase)
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- reg_data  in  NUM_REGS*DATA_WIDTH  flattened register values; register i is at bits [i*DATA_WIDTH +: DATA_WIDTH]
- PRDATA  out  DATA_WIDTH  registered read data
- PREADY  out  1  registered transfer-complete
- PSLVERR  out  1  registered error; valid only while PREADY=1
- rd_strobe  out  1  one-cycle pulse on a completed mapped read
- rd_index  out  $clog2(NUM_REGS) (minimum 1)  index of the register being read; valid while rd_strobe=1

## Operation
- **Reset values.** PRDATA=0, PREADY=0, PSLVERR=0, rd_strobe=0, rd_index=0, state=IDLE, wait counter=0.
- **Address decode.** Done once, in the setup cycle (PSEL=1, PENABLE=0).
  - offset = PADDR − ADDR_BASE, computed at ADDR_WIDTH bits.
  - mapped = (PADDR ≥ ADDR_BASE) && (offset[1:0]==0) && (offset[ADDR_WIDTH-1:2] < NUM_REGS).
  - Index, mapped flag and PWRITE are captured at this edge. Later changes to PADDR or PWRITE are ignored.
- **FSM states.**
  - IDLE: on a setup cycle, capture the request and load cnt=WAIT_STATES. Go to RESP if WAIT_STATES==0, otherwise go to WAIT.
  - WAIT: cnt decrements each cycle. When cnt==1, go to RESP. If PSEL falls (protocol violation), abort to IDLE with no PREADY, no strobe and PRDATA=0.
  - RESP: PREADY=1 for exactly one cycle, then IDLE.
- **Outputs in RESP.**
  - Mapped read: PRDATA = reg_data[index], sampled at the edge entering RESP. PSLVERR=0, rd_strobe=1, rd_index=index.
  - Unmapped read: PRDATA=0, PSLVERR=1, rd_strobe=0.
  - Mapped write: PRDATA=0, PSLVERR=0, rd_strobe=0. Write data is handled by the register file, not this block.
  - Unmapped write: PRDATA=0, PSLVERR=1.
- **Outside RESP.** PRDATA, PSLVERR and rd_strobe are driven 0.
- **Back-to-back transfers.** The IDLE cycle following RESP may itself be the next setup cycle and is accepted. No dead cycle is inserted.
- **Reset mid-transfer.** Outputs clear immediately (asynchronous). The interrupted transfer is dropped.

## Timing
- T0 is the setup cycle, T1 the first access cycle.
- PREADY is high in cycle T1+WAIT_STATES only; a transfer takes 2+WAIT_STATES cycles.
- PRDATA reflects reg_data as of the last cycle before RESP: T0 for WAIT_STATES=0, T0+WAIT_STATES in general.
- Register changes after that sample are not visible until the next read.
- rd_strobe is coincident with PREADY, one pulse per completed mapped read.
- All outputs are flop outputs; there is no combinational path from APB inputs to outputs.

## Test plan
- **Reset.** Assert PRESETn=0 mid-WAIT with WAIT_STATES=3 → all outputs 0 immediately. After release, the first read completes normally.
- **Zero-wait read sweep.** WAIT_STATES=0, read 0x0009_0000..0x0009_004C with reg_data[i]=32'hA5A5_0000+i.
  - Each read: PREADY in T1, PRDATA=32'hA5A5_0000+i, PSLVERR=0.
  - rd_strobe pulses once per read with rd_index=i.
- **Wait states.** WAIT_STATES=3, read 0x0009_0010 → PREADY=0 in T1..T3 and PREADY=1 in T4.
  - PRDATA equals reg_data[4] as sampled at T3, even though reg_data[4] changed at T1.
- **Unmapped and misaligned.** Read 0x0009_0050, 0x0009_0002 and 0x0008_FFFC → PREADY in T1, PSLVERR=1, PRDATA=0, no rd_strobe.
- **Writes.** Write 0x0009_000C → PREADY in T1+WAIT_STATES, PSLVERR=0, PRDATA=0, no strobe. Write 0x0009_0100 → PSLVERR=1.
- **Back-to-back and abort.** Read reg 0 then, with setup in the cycle after PREADY, read reg 19 → two strobes, indices 0 then 19. With WAIT_STATES=2, drop PSEL in T1 → no PREADY or strobe; the next transfer is correct.

Source files
------------

// File: rtl/apb_reg_read_ctrl.sv
// apb_reg_read_ctrl: APB slave read-back controller for the
// interrupt controller register bank.
//
// Decodes PADDR against ADDR_BASE/NUM_REGS in the setup cycle,
// inserts WAIT_STATES access cycles, then returns registered
// PRDATA/PREADY/PSLVERR for one cycle.
//
// Ports:
//   PCLK, PRESETn            clock, async active-low reset
//   PSEL, PENABLE, PWRITE    APB control
//   PADDR                    byte address
//   reg_data                 flattened register values
//   PRDATA, PREADY, PSLVERR  registered APB response
//   rd_strobe, rd_index      pulse + index on a completed mapped read
module apb_reg_read_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 20,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = 32'h0009_0000,
  parameter int WAIT_STATES = 0,
  localparam int IDX_W =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_data,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic                           rd_strobe,
  output logic [IDX_W-1:0]               rd_index
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int NSLOT = 1 << IDX_W;
  localparam logic [AW-3:0] NREGS_A = (AW-2)'(NUM_REGS);
  localparam logic [3:0] WS_L = 4'(WAIT_STATES);
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             map_q, map_d;
  logic             wr_q, wr_d;

  logic [DW-1:0]    prdata_q, prdata_d;
  logic             pready_q, pready_d;
  logic             pslverr_q, pslverr_d;
  logic             strobe_q, strobe_d;
  logic [IDX_W-1:0] rdidx_q, rdidx_d;

  // Register slots padded to a power of two so an index that
  // decodes past NUM_REGS still selects a defined (zero) value.
  logic [DW-1:0] regs [NSLOT];

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NUM_REGS) begin : g_map
      assign regs[g] = reg_data[g*DW +: DW];
    end else begin : g_pad
      assign regs[g] = '0;
    end
  end

  logic [AW-1:0]    offset;
  logic [AW-3:0]    word;
  logic             dec_map;
  logic [IDX_W-1:0] dec_idx;
  logic             setup;

  assign offset  = PADDR - ADDR_BASE;
  assign word    = offset[AW-1:2];
  assign dec_map = (PADDR >= ADDR_BASE) &&
                   (offset[1:0] == 2'b00) &&
                   (word < NREGS_A);
  assign dec_idx = word[IDX_W-1:0];
  assign setup   = PSEL && !PENABLE;

  // Response source: with zero wait states the response is
  // formed straight from the live decode, otherwise from the
  // request captured in the setup cycle.
  logic             go_resp;
  logic [IDX_W-1:0] rsp_idx;
  logic             rsp_map;
  logic             rsp_wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    map_d   = map_q;
    wr_d    = wr_q;
    go_resp = 1'b0;
    rsp_idx = idx_q;
    rsp_map = map_q;
    rsp_wr  = wr_q;

    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          idx_d = dec_idx;
          map_d = dec_map;
          wr_d  = PWRITE;
          cnt_d = WS_L;
          if (ZERO_WAIT) begin
            state_d = S_RESP;
            go_resp = 1'b1;
            rsp_idx = dec_idx;
            rsp_map = dec_map;
            rsp_wr  = PWRITE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          // master dropped the transfer: abort silently
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    strobe_d  = 1'b0;
    rdidx_d   = rdidx_q;
    if (go_resp) begin
      pready_d  = 1'b1;
      pslverr_d = !rsp_map;
      if (rsp_map && !rsp_wr) begin
        prdata_d = regs[rsp_idx];
        strobe_d = 1'b1;
        rdidx_d  = rsp_idx;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      map_q     <= 1'b0;
      wr_q      <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      strobe_q  <= 1'b0;
      rdidx_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      map_q     <= map_d;
      wr_q      <= wr_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      strobe_q  <= strobe_d;
      rdidx_q   <= rdidx_d;
    end
  end

  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign rd_strobe = strobe_q;
  assign rd_index  = rdidx_q;

endmodule
